rr_tag_sched: RTL and testbench

- Schedules DMA read requests from up to four host-to-FPGA channels onto the single read-request (rr) port of the PCIe TX engine.
- Allocates a unique PCIe tag per request from a per-channel 8-slot pool and enforces a global outstanding-request limit.
- Frees tags when the RX completion path reports that a tag's final completion has arrived.
- Every request is a fixed 512-byte (128 DW) memory read.

---
 rtl/rr_tag_sched.sv | 182 ++++++++++++++++++
 tb/tb_rr_tag_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_tag_sched.sv
// rr_tag_sched -- read-request scheduler for the PCIe TX read-request port.
//
// Arbitrates DMA read requests from up to NCH host-to-FPGA channels in
// round-robin order. Each accepted request gets a PCIe tag from that
// channel's 8-slot pool, and the number of requests in flight is capped
// globally at MAX_OUT. Tags come back through the completion path
// (cpl_valid/cpl_tag) once their final completion has arrived.
// Every request is a fixed 512-byte read, so address bits [8:0] are dropped.
//
// Ports:
//   clock, reset     system clock; synchronous active-high reset
//   ch_valid[NCH]    channel has a request pending (held until ch_ready)
//   ch_addr[64*NCH]  request byte address, channel i at [64*i+63:64*i]
//   ch_ready[NCH]    one-cycle accept pulse to the granted channel
//   ch_slot[3]       slot given to the accepted request (valid with ch_ready)
//   rr_valid/rr_ready/rr_addr/rr_tag  request handshake to the TX engine
//   cpl_valid/cpl_tag  tag release from the completion path
//   outstanding[6]   number of tags currently busy
//   err_release      sticky flag: a release named a tag that was not busy
module rr_tag_sched #(
    parameter int NCH     = 4,
    parameter int MAX_OUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH-1:0]    ch_valid,
    input  logic [64*NCH-1:0] ch_addr,
    output logic [NCH-1:0]    ch_ready,
    output logic [2:0]        ch_slot,
    output logic              rr_valid,
    input  logic              rr_ready,
    output logic [63:0]       rr_addr,
    output logic [7:0]        rr_tag,
    input  logic              cpl_valid,
    input  logic [7:0]        cpl_tag,
    output logic [5:0]        outstanding,
    output logic              err_release
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t              state_p0;
    logic [8*NCH-1:0]    busy_p0;      // bit 8*ch+slot set while that tag is in flight
    logic [1:0]          ptr_p0;       // round-robin start point

    logic                can_issue;
    logic [NCH-1:0]      elig;
    logic                grant_any;
    logic [1:0]          grant_ch;
    logic [NCH-1:0]      grant_onehot;
    logic [2:0]          grant_slot;
    logic [63:0]         grant_addr;
    logic [1:0]          ptr_next;
    logic                do_alloc;
    logic [8*NCH-1:0]    alloc_mask;
    logic                rel_hit;
    logic                rel_ok;
    logic                rel_bad;
    logic [8*NCH-1:0]    release_mask;

    // Eligibility, round-robin pick and slot choice, all from the pre-edge
    // busy bitmap so a tag released this cycle is not handed out again
    // until the next one.
    always_comb begin
        can_issue = (outstanding < 6'(MAX_OUT));
        for (int i = 0; i < NCH; i++) begin
            elig[i] = ch_valid[i] & ~(&busy_p0[8*i +: 8]) & can_issue;
        end

        // Scan from the farthest candidate back to the pointer so the last
        // match wins: that is the first eligible channel at/after ptr_p0.
        grant_any = 1'b0;
        grant_ch  = 2'd0;
        for (int k = NCH - 1; k >= 0; k--) begin
            for (int i = 0; i < NCH; i++) begin
                if (elig[i] && (((int'(ptr_p0) + k) % NCH) == i)) begin
                    grant_any = 1'b1;
                    grant_ch  = 2'(i);
                end
            end
        end

        grant_onehot = '0;
        grant_addr   = 64'd0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_ch == 2'(i)) begin
                grant_onehot[i] = 1'b1;
                grant_addr      = ch_addr[64*i +: 64];
            end
        end

        // Lowest free slot of the granted channel.
        grant_slot = 3'd0;
        for (int s = 7; s >= 0; s--) begin
            for (int i = 0; i < NCH; i++) begin
                if ((grant_ch == 2'(i)) && !busy_p0[8*i + s]) begin
                    grant_slot = 3'(s);
                end
            end
        end

        ptr_next = (grant_ch == 2'(NCH - 1)) ? 2'd0 : grant_ch + 2'd1;

        do_alloc   = (state_p0 == IDLE) && grant_any;
        alloc_mask = '0;
        for (int b = 0; b < 8*NCH; b++) begin
            alloc_mask[b] = do_alloc && (5'(b) == {grant_ch, grant_slot});
        end
    end

    // Release decode. Matching the tag against every bit position also
    // rejects channel numbers at or above NCH, since no such bit exists.
    always_comb begin
        rel_hit = 1'b0;
        for (int b = 0; b < 8*NCH; b++) begin
            if ((cpl_tag[4:0] == 5'(b)) && busy_p0[b]) begin
                rel_hit = 1'b1;
            end
        end
        rel_ok  = cpl_valid && (cpl_tag[7:5] == 3'd0) && rel_hit;
        rel_bad = cpl_valid && !rel_ok;

        release_mask = '0;
        for (int b = 0; b < 8*NCH; b++) begin
            release_mask[b] = rel_ok && (cpl_tag[4:0] == 5'(b));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_p0    <= IDLE;
            busy_p0     <= '0;
            ptr_p0      <= 2'd0;
            ch_ready    <= '0;
            ch_slot     <= 3'd0;
            rr_valid    <= 1'b0;
            rr_addr     <= 64'd0;
            rr_tag      <= 8'd0;
            outstanding <= 6'd0;
            err_release <= 1'b0;
        end else begin
            busy_p0  <= (busy_p0 & ~release_mask) | alloc_mask;
            ch_ready <= '0;

            // An allocation and a release in the same cycle cancel out.
            if (do_alloc && !rel_ok) begin
                outstanding <= outstanding + 6'd1;
            end else if (!do_alloc && rel_ok) begin
                outstanding <= outstanding - 6'd1;
            end

            if (rel_bad) begin
                err_release <= 1'b1;
            end

            case (state_p0)
                IDLE: begin
                    if (grant_any) begin
                        ch_ready <= grant_onehot;
                        ch_slot  <= grant_slot;
                        rr_addr  <= grant_addr & ~64'h1FF;
                        rr_tag   <= {3'b000, grant_ch, grant_slot};
                        rr_valid <= 1'b1;
                        ptr_p0   <= ptr_next;
                        state_p0 <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rr_ready) begin
                        rr_valid <= 1'b0;
                        state_p0 <= IDLE;
                    end
                end
                default: state_p0 <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_tag_sched.sv
module tb_rr_tag_sched;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   ch_valid = '0;
    logic [255:0] ch_addr;
    logic [3:0]   ch_ready;
    logic [2:0]   ch_slot;
    logic         rr_valid;
    logic         rr_ready = 1'b0;
    logic [63:0]  rr_addr;
    logic [7:0]   rr_tag;
    logic         cpl_valid = 1'b0;
    logic [7:0]   cpl_tag = '0;
    logic [5:0]   outstanding;
    logic         err_release;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    rr_tag_sched #(.NCH(4), .MAX_OUT(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .ch_valid    (ch_valid),
        .ch_addr     (ch_addr),
        .ch_ready    (ch_ready),
        .ch_slot     (ch_slot),
        .rr_valid    (rr_valid),
        .rr_ready    (rr_ready),
        .rr_addr     (rr_addr),
        .rr_tag      (rr_tag),
        .cpl_valid   (cpl_valid),
        .cpl_tag     (cpl_tag),
        .outstanding (outstanding),
        .err_release (err_release)
    );

    function automatic logic [63:0] addr_of(input int c);
        case (c)
            0:       return 64'h0000_0001_2345_67FF;
            1:       return 64'h0000_00AB_CDEF_0123;
            2:       return 64'h1234_5678_9ABC_DE00;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    assign ch_addr = {addr_of(3), addr_of(2), addr_of(1), addr_of(0)};

    typedef struct {
        logic       rst;
        logic [3:0] cv;
        logic       rdy;
        logic       e_rv;
        logic [3:0] e_cr;
        logic [2:0] e_slot;
        logic [7:0] e_tag;
        logic [5:0] e_out;
    } vec_t;

    vec_t vt[18];

    function automatic vec_t mk(input logic rst, input logic [3:0] cv, input logic rdy,
                                input logic rv, input logic [3:0] cr, input logic [2:0] slot,
                                input logic [7:0] tag, input logic [5:0] out);
        vec_t v;
        v.rst = rst; v.cv = cv; v.rdy = rdy; v.e_rv = rv; v.e_cr = cr;
        v.e_slot = slot; v.e_tag = tag; v.e_out = out;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        ch_valid  = '0;
        rr_ready  = 1'b0;
        cpl_valid = 1'b0;
        cpl_tag   = '0;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
    endtask

    task automatic release_tag(input logic [7:0] t);
        cpl_valid = 1'b1;
        cpl_tag   = t;
        step();
        cpl_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int grants;
        logic [7:0] etag;

        // Single request (rows 0..5), then round robin (rows 6..17).
        vt[0]  = mk(1, 4'h1, 0, 0, 4'h0, 3'd0, 8'h00, 6'd0);
        vt[1]  = mk(0, 4'h0, 0, 1, 4'h1, 3'd0, 8'h00, 6'd1);
        vt[2]  = mk(0, 4'h0, 0, 1, 4'h0, 3'd0, 8'h00, 6'd1);
        vt[3]  = mk(0, 4'h0, 1, 1, 4'h0, 3'd0, 8'h00, 6'd1);
        vt[4]  = mk(0, 4'h0, 0, 0, 4'h0, 3'd0, 8'h00, 6'd1);
        vt[5]  = mk(0, 4'h0, 0, 0, 4'h0, 3'd0, 8'h00, 6'd1);
        vt[6]  = mk(1, 4'hF, 1, 0, 4'h0, 3'd0, 8'h00, 6'd0);
        vt[7]  = mk(0, 4'hF, 1, 1, 4'h1, 3'd0, 8'h00, 6'd1);
        vt[8]  = mk(0, 4'hF, 1, 0, 4'h0, 3'd0, 8'h00, 6'd1);
        vt[9]  = mk(0, 4'hF, 1, 1, 4'h2, 3'd0, 8'h08, 6'd2);
        vt[10] = mk(0, 4'hF, 1, 0, 4'h0, 3'd0, 8'h00, 6'd2);
        vt[11] = mk(0, 4'hF, 1, 1, 4'h4, 3'd0, 8'h10, 6'd3);
        vt[12] = mk(0, 4'hF, 1, 0, 4'h0, 3'd0, 8'h00, 6'd3);
        vt[13] = mk(0, 4'hF, 1, 1, 4'h8, 3'd0, 8'h18, 6'd4);
        vt[14] = mk(0, 4'hF, 1, 0, 4'h0, 3'd0, 8'h00, 6'd4);
        vt[15] = mk(0, 4'hF, 1, 1, 4'h1, 3'd1, 8'h01, 6'd5);
        vt[16] = mk(0, 4'hF, 1, 0, 4'h0, 3'd0, 8'h00, 6'd5);
        vt[17] = mk(0, 4'hF, 1, 1, 4'h2, 3'd1, 8'h09, 6'd6);

        // Reset state.
        do_reset();
        check("reset_rr_valid", 64'(rr_valid), 64'd0);
        check("reset_ch_ready", 64'(ch_ready), 64'd0);
        check("reset_ch_slot", 64'(ch_slot), 64'd0);
        check("reset_rr_addr", rr_addr, 64'd0);
        check("reset_rr_tag", 64'(rr_tag), 64'd0);
        check("reset_outstanding", 64'(outstanding), 64'd0);
        check("reset_err_release", 64'(err_release), 64'd0);

        // Table-driven single-request and round-robin sequences.
        for (int i = 0; i < 18; i++) begin
            if (vt[i].rst) do_reset();
            ch_valid = vt[i].cv;
            rr_ready = vt[i].rdy;
            #1;
            check($sformatf("row%0d_rr_valid", i), 64'(rr_valid), 64'(vt[i].e_rv));
            check($sformatf("row%0d_ch_ready", i), 64'(ch_ready), 64'(vt[i].e_cr));
            check($sformatf("row%0d_outstanding", i), 64'(outstanding), 64'(vt[i].e_out));
            check($sformatf("row%0d_err_release", i), 64'(err_release), 64'd0);
            if (vt[i].e_cr != 4'h0)
                check($sformatf("row%0d_ch_slot", i), 64'(ch_slot), 64'(vt[i].e_slot));
            if (vt[i].e_rv) begin
                check($sformatf("row%0d_rr_tag", i), 64'(rr_tag), 64'(vt[i].e_tag));
                check($sformatf("row%0d_rr_addr", i), rr_addr,
                      addr_of(int'(vt[i].e_tag[4:3])) & ~64'h1FF);
            end
            if (i == 1) check("single_rr_addr_abs", rr_addr, 64'h0000_0001_2345_6600);
            step();
        end

        // Global limit: 16 grants in round-robin order, then silence.
        do_reset();
        ch_valid = 4'hF;
        rr_ready = 1'b1;
        grants = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (rr_valid) begin
                etag = 8'(((grants % 4) << 3) | (grants / 4));
                if (grants < 16) check($sformatf("limit_tag%0d", grants), 64'(rr_tag), 64'(etag));
                grants++;
            end
        end
        check("limit_grants", 64'(grants), 64'd16);
        check("limit_outstanding", 64'(outstanding), 64'd16);
        ch_valid = 4'b0010;
        release_tag(8'h09);
        check("limit_after_release_out", 64'(outstanding), 64'd15);
        check("limit_after_release_rv", 64'(rr_valid), 64'd0);
        step();
        check("limit_regrant_rv", 64'(rr_valid), 64'd1);
        check("limit_regrant_tag", 64'(rr_tag), 64'h09);
        check("limit_regrant_ch_ready", 64'(ch_ready), 64'b0010);
        check("limit_regrant_slot", 64'(ch_slot), 64'd1);
        check("limit_regrant_out", 64'(outstanding), 64'd16);

        // Channel full: only channel 2 requests, 8 slots then stall.
        do_reset();
        ch_valid = 4'b0100;
        rr_ready = 1'b1;
        grants = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (rr_valid) begin
                if (grants < 8) check($sformatf("full_tag%0d", grants), 64'(rr_tag), 64'(8'h10 + 8'(grants)));
                grants++;
            end
        end
        check("full_grants", 64'(grants), 64'd8);
        check("full_outstanding", 64'(outstanding), 64'd8);
        release_tag(8'h13);
        step();
        check("full_regrant_rv", 64'(rr_valid), 64'd1);
        check("full_regrant_tag", 64'(rr_tag), 64'h13);
        check("full_regrant_out", 64'(outstanding), 64'd8);

        // Release and allocation in the same cycle.
        do_reset();
        ch_valid = 4'b0001;
        rr_ready = 1'b1;
        step();
        check("simul_first_tag", 64'(rr_tag), 64'h00);
        check("simul_first_out", 64'(outstanding), 64'd1);
        step();
        check("simul_idle_rv", 64'(rr_valid), 64'd0);
        release_tag(8'h00);
        ch_valid = 4'b0000;
        check("simul_grant_rv", 64'(rr_valid), 64'd1);
        check("simul_grant_tag", 64'(rr_tag), 64'h01);
        check("simul_grant_slot", 64'(ch_slot), 64'd1);
        check("simul_out", 64'(outstanding), 64'd1);
        check("simul_err", 64'(err_release), 64'd0);
        step();
        step();

        // Bad releases: reserved bits set, then a free tag.
        release_tag(8'h20);
        check("bad20_err", 64'(err_release), 64'd1);
        check("bad20_out", 64'(outstanding), 64'd1);
        release_tag(8'h01);
        check("bad20_busy_kept_out", 64'(outstanding), 64'd0);
        do_reset();
        check("bad_reset_err", 64'(err_release), 64'd0);
        release_tag(8'h05);
        check("bad05_err", 64'(err_release), 64'd1);
        check("bad05_out", 64'(outstanding), 64'd0);

        // Reset while a request is being issued.
        do_reset();
        ch_valid = 4'b0001;
        rr_ready = 1'b0;
        step();
        check("midissue_rv_before", 64'(rr_valid), 64'd1);
        ch_valid = 4'b0000;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midissue_rv_after", 64'(rr_valid), 64'd0);
        check("midissue_out_after", 64'(outstanding), 64'd0);
        release_tag(8'h00);
        check("midissue_stale_err", 64'(err_release), 64'd1);
        check("midissue_stale_out", 64'(outstanding), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
